pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared MIPS definitions: PC/WB select codes, stage indices and the
// hazard-controller FSM encodings.
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] PC_SEL_NEXT   = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
  localparam logic [1:0] PC_SEL_JR     = 2'd3;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;

  // Stage positions inside the packed {if, id, exe, mem, wb} control vectors
  localparam int STG_IF  = 4;
  localparam int STG_ID  = 3;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 0;

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_ERR      = 2'd3;

  localparam int MEM_TIMEOUT_DEF = 255;

  function automatic logic [4:0] inst_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] inst_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW comparator: ID source registers against pending EXE/MEM
// writes. WB is not checked because the register file writes through.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [31:0] inst_data_id_i,
  input  logic        rs_used_i,
  input  logic        rt_used_i,
  input  logic [4:0]  regw_addr_exe_i,
  input  logic [4:0]  regw_addr_mem_i,
  input  logic        wb_wen_exe_i,
  input  logic        wb_wen_mem_i,
  output logic        raw_hazard_o
);

  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_hit;
  logic       rt_hit;

  assign rs = inst_rs(inst_data_id_i);
  assign rt = inst_rt(inst_data_id_i);

  // $0 is hard-wired to zero, so a write to it never creates a dependency
  assign rs_hit = rs_used_i && (rs != 5'd0) &&
                  ((wb_wen_exe_i && (regw_addr_exe_i == rs)) ||
                   (wb_wen_mem_i && (regw_addr_mem_i == rs)));
  assign rt_hit = rt_used_i && (rt != 5'd0) &&
                  ((wb_wen_exe_i && (regw_addr_exe_i == rt)) ||
                   (wb_wen_mem_i && (regw_addr_mem_i == rt)));

  assign raw_hazard_o = rs_hit || rt_hit;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline controller: boot flush, RAW stalls, branch flushes,
// data-memory wait freeze with timeout, and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_data_id,
  input  logic             rs_used_ctrl,
  input  logic             rt_used_ctrl,
  input  logic             is_branch_exe,
  input  logic             is_branch_mem,
  input  logic [4:0]       regw_addr_exe,
  input  logic [4:0]       regw_addr_mem,
  input  logic             wb_wen_exe,
  input  logic             wb_wen_mem,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             if_rst,
  output logic             id_rst,
  output logic             exe_rst,
  output logic             mem_rst,
  output logic             wb_rst,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [1:0]        state_q, state_d;
  logic [BOOT_W-1:0] boot_q, boot_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q;
  logic              err_q;
  logic [4:0]        rst_v;
  logic [4:0]        en_v;
  logic              raw_hazard;
  logic              mem_stall;

  hazard_detect u_hazard_detect (
    .inst_data_id_i  (inst_data_id),
    .rs_used_i       (rs_used_ctrl),
    .rt_used_i       (rt_used_ctrl),
    .regw_addr_exe_i (regw_addr_exe),
    .regw_addr_mem_i (regw_addr_mem),
    .wb_wen_exe_i    (wb_wen_exe),
    .wb_wen_mem_i    (wb_wen_mem),
    .raw_hazard_o    (raw_hazard)
  );

  // A wait only starts on a request in RUN; once in MEM_WAIT only the ack matters
  assign mem_stall = ((state_q == ST_RUN) && mem_req && !mem_ack) ||
                     ((state_q == ST_MEM_WAIT) && !mem_ack);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    boot_d  = boot_q;
    wait_d  = wait_q;
    rst_v   = 5'b00000;
    en_v    = 5'b11111;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          en_v         = 5'b00001;
          rst_v[STG_WB] = 1'b1;
          if (state_q == ST_RUN) begin
            state_d = ST_MEM_WAIT;
            wait_d  = '0;
          end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = ST_ERR;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          state_d = ST_RUN;
          // Branch resolution in MEM redirects the PC, so IF must load the target
          if (is_branch_mem) begin
            rst_v[STG_ID]  = 1'b1;
            rst_v[STG_EXE] = 1'b1;
          end else if (is_branch_exe) begin
            rst_v[STG_ID]  = 1'b1;
            rst_v[STG_EXE] = 1'b1;
          end else if (raw_hazard) begin
            en_v[STG_IF]   = 1'b0;
            en_v[STG_ID]   = 1'b0;
            rst_v[STG_EXE] = 1'b1;
          end
        end
      end
      ST_ERR: begin
        en_v = 5'b00000;
      end
      default: begin
        rst_v = 5'b11111;
        en_v  = 5'b00000;
        if (boot_q == BOOT_W'(BOOT_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          boot_d = boot_q + 1'b1;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      boot_q  <= '0;
      wait_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      wait_q  <= wait_d;
      if (state_d == ST_ERR) begin
        err_q <= 1'b1;
      end
      if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) &&
          !en_v[STG_IF] && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign if_rst    = rst_v[STG_IF];
  assign id_rst    = rst_v[STG_ID];
  assign exe_rst   = rst_v[STG_EXE];
  assign mem_rst   = rst_v[STG_MEM];
  assign wb_rst    = rst_v[STG_WB];
  assign if_en     = en_v[STG_IF];
  assign id_en     = en_v[STG_ID];
  assign exe_en    = en_v[STG_EXE];
  assign mem_en    = en_v[STG_MEM];
  assign wb_en     = en_v[STG_WB];
  assign err       = err_q;
  assign stall_cnt = stall_q;

endmodule
